// File: rtl/operand_route_pipe.sv
// Registered operand router: picks ALU operands A/B from the register file (with
// write-back forwarding) into a valid/ready stage, and registers the ALU result as a one-hot write.
module operand_route_pipe #(
    parameter int WORD_SIZE = 8,
    parameter int NUM_SRC   = 8,
    parameter int SEL_W     = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_SRC*WORD_SIZE-1:0] src_bus,
    input  logic [WORD_SIZE-1:0]         imm,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [SEL_W-1:0]             sel_a,
    input  logic [SEL_W-1:0]             sel_b,
    input  logic [SEL_W-1:0]             dest_sel,
    output logic                         op_valid,
    input  logic                         op_ready,
    output logic [WORD_SIZE-1:0]         op_a,
    output logic [WORD_SIZE-1:0]         op_b,
    output logic [SEL_W-1:0]             op_dest,
    input  logic                         wb_valid,
    input  logic [WORD_SIZE-1:0]         wb_value,
    input  logic [SEL_W-1:0]             wb_dest,
    output logic [WORD_SIZE-1:0]         wb_data,
    output logic [NUM_SRC-1:0]           wb_en,
    output logic [7:0]                   err_cnt
);

    if (NUM_SRC < 2 || NUM_SRC > 16) begin : g_bad_num_src
        $error("operand_route_pipe: NUM_SRC must be in 2..16");
    end
    if ((1 << SEL_W) < NUM_SRC + 1) begin : g_bad_sel_w
        $error("operand_route_pipe: SEL_W too narrow to encode NUM_SRC+1 selections");
    end

    // Selector code NUM_SRC means "immediate" for B; anything above it is illegal.
    localparam logic [SEL_W-1:0] SRC_LIMIT = SEL_W'(NUM_SRC);

    logic                 capture;
    logic                 a_legal;
    logic                 b_legal;
    logic                 b_is_imm;
    logic                 wb_dest_legal;
    logic                 wb_legal;
    logic                 issue_err;
    logic                 wb_err;
    logic [WORD_SIZE-1:0] a_src;
    logic [WORD_SIZE-1:0] b_src;
    logic [WORD_SIZE-1:0] a_next;
    logic [WORD_SIZE-1:0] b_next;
    logic [1:0]           err_inc;
    logic [8:0]           err_sum;
    logic [7:0]           err_next;
    logic [NUM_SRC-1:0]   wb_onehot;

    assign in_ready = !op_valid || op_ready;
    assign capture  = in_valid && in_ready;

    assign a_legal       = sel_a < SRC_LIMIT;
    assign b_legal       = sel_b < SRC_LIMIT;
    assign b_is_imm      = sel_b == SRC_LIMIT;
    assign wb_dest_legal = wb_dest < SRC_LIMIT;
    assign wb_legal      = wb_valid && wb_dest_legal;

    // NOTE: every output of an always_comb gets a default before any conditional
    // assignment, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        a_src = '0;
        b_src = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (sel_a == SEL_W'(i)) a_src = src_bus[i*WORD_SIZE +: WORD_SIZE];
            if (sel_b == SEL_W'(i)) b_src = src_bus[i*WORD_SIZE +: WORD_SIZE];
        end
    end

    // A result being written back this cycle is newer than the register file copy.
    always_comb begin
        a_next = '0;
        if (a_legal) begin
            a_next = (wb_legal && wb_dest == sel_a) ? wb_value : a_src;
        end
    end

    always_comb begin
        b_next = '0;
        if (b_is_imm) begin
            b_next = imm;
        end else if (b_legal) begin
            b_next = (wb_legal && wb_dest == sel_b) ? wb_value : b_src;
        end
    end

    assign issue_err = capture && (!a_legal || !(b_legal || b_is_imm));
    assign wb_err    = wb_valid && !wb_dest_legal;
    assign err_inc   = {1'b0, issue_err} + {1'b0, wb_err};
    assign err_sum   = {1'b0, err_cnt} + {7'b0, err_inc};
    assign err_next  = err_sum[8] ? 8'hFF : err_sum[7:0];

    assign wb_onehot = {{(NUM_SRC-1){1'b0}}, 1'b1} << wb_dest;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values and the block order cannot create false dependencies.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_valid <= 1'b0;
            op_a     <= '0;
            op_b     <= '0;
            op_dest  <= '0;
        end else if (capture) begin
            op_valid <= 1'b1;
            op_a     <= a_next;
            op_b     <= b_next;
            op_dest  <= dest_sel;
        end else if (op_ready) begin
            op_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wb_en   <= '0;
            wb_data <= '0;
        end else begin
            wb_en <= wb_legal ? wb_onehot : '0;
            if (wb_legal) wb_data <= wb_value;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) err_cnt <= '0;
        else       err_cnt <= err_next;
    end

endmodule
